// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Types and constants shared by the memory arbiter and its watchdog.
//   - ramstate_t  : handshake state reported by the single-ported RAM
//   - arb_state_t : arbiter FSM states
//   - FAULT_WORD  : load value returned for a request that faulted
//   - data_pending: helper that folds the data-side read/write strobes
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2,
        FAULT  = 2'd3
    } arb_state_t;

    localparam logic [31:0] FAULT_WORD = 32'hBAD0BAD0;

    // A data request is pending on either strobe; a write wins when both are high.
    function automatic logic data_pending(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// -----------------------------------------------------------------------------
// arb_watchdog
//   Per-grant retry and timeout counters for the memory arbiter.
//   Ports:
//     i_clk      clock
//     i_nrst     asynchronous active-low reset
//     i_clr      clear both counters (no grant active, or grant completed)
//     i_busy     RAM stalled this cycle (BUSY or FREE) during a grant
//     i_err      RAM reported ERROR this cycle during a grant
//     o_expired  this cycle's busy/err event reaches its limit
// -----------------------------------------------------------------------------
module arb_watchdog #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_clr,
    input  logic i_busy,
    input  logic i_err,
    output logic o_expired
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    logic [TW-1:0] r_timeout;
    logic [RW-1:0] r_retry;
    logic          w_timeout_hit;
    logic          w_retry_hit;

    // Expiry is flagged on the event that would make the count reach its limit,
    // so the arbiter can leave the grant on that same edge.
    assign w_timeout_hit = i_busy && (r_timeout == TW'(TIMEOUT - 1));
    assign w_retry_hit   = i_err  && (r_retry   == RW'(MAX_RETRY - 1));
    assign o_expired     = w_timeout_hit || w_retry_hit;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_timeout <= '0;
            r_retry   <= '0;
        end else if (i_clr) begin
            r_timeout <= '0;
            r_retry   <= '0;
        end else begin
            if (i_busy) begin
                r_timeout <= r_timeout + TW'(1);
            end
            if (i_err) begin
                r_retry <= r_retry + RW'(1);
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Arbitrates instruction-fetch and data-access requests onto a single-ported
//   RAM. A granted request is latched and replayed unchanged until the RAM
//   answers ACCESS; ERROR responses retry, BUSY/FREE stall. Exceeding the retry
//   or timeout limit completes the request with FAULT_WORD and sets memfault.
//   Ports:
//     CLK, nRST                 clock, asynchronous active-low reset
//     iREN, iaddr               instruction read request
//     iload, iwait              instruction data / stall (low one cycle on completion)
//     dREN, dWEN, daddr, dstore data read/write request
//     dload, dwait              data read data / stall (low one cycle on completion)
//     ramREN, ramWEN            RAM enables, driven only from the latched request
//     ramaddr, ramstore         RAM address / write data, from the latched request
//     ramload, ramstate         RAM read data / handshake state (ramstate_t)
//     memfault                  sticky fault flag, cleared only by reset
// -----------------------------------------------------------------------------
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              memfault
);

    arb_state_t        r_state;
    logic              r_last_d;
    logic              r_memfault;
    logic              r_is_d;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_store;

    ramstate_t         w_ramstate;
    logic              w_granted;
    logic              w_access;
    logic              w_busy;
    logic              w_err;
    logic              w_expired;
    logic              w_wd_clr;
    logic              w_d_pending;
    logic              w_pick_d;
    logic              w_done;
    logic [DATA_W-1:0] w_load;

    assign w_ramstate = ramstate_t'(ramstate);
    assign w_granted  = (r_state == DGRANT) || (r_state == IGRANT);
    assign w_access   = w_granted && (w_ramstate == ACCESS);
    assign w_busy     = w_granted && ((w_ramstate == BUSY) || (w_ramstate == FREE));
    assign w_err      = w_granted && (w_ramstate == ERROR);

    // Counters are per grant: idle, fault and a successful access all restart them.
    assign w_wd_clr = !w_granted || w_access;

    arb_watchdog #(
        .TIMEOUT  (TIMEOUT),
        .MAX_RETRY(MAX_RETRY)
    ) u_watchdog (
        .i_clk    (CLK),
        .i_nrst   (nRST),
        .i_clr    (w_wd_clr),
        .i_busy   (w_busy),
        .i_err    (w_err),
        .o_expired(w_expired)
    );

    // Data wins unless the instruction side is also asking and data had the last grant.
    assign w_d_pending = data_pending(dREN, dWEN);
    assign w_pick_d    = w_d_pending && (!iREN || !r_last_d);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_last_d   <= 1'b0;
            r_memfault <= 1'b0;
            r_is_d     <= 1'b0;
            r_wen      <= 1'b0;
            r_addr     <= '0;
            r_store    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_state  <= DGRANT;
                        r_last_d <= 1'b1;
                        r_is_d   <= 1'b1;
                        r_wen    <= dWEN;
                        r_addr   <= daddr;
                        r_store  <= dstore;
                    end else if (iREN) begin
                        r_state  <= IGRANT;
                        r_last_d <= 1'b0;
                        r_is_d   <= 1'b0;
                        r_wen    <= 1'b0;
                        r_addr   <= iaddr;
                        r_store  <= '0;
                    end
                end
                DGRANT, IGRANT: begin
                    // ERROR and BUSY keep the latched request on the bus unchanged.
                    if (w_access) begin
                        r_state <= IDLE;
                    end else if (w_expired) begin
                        r_state    <= FAULT;
                        r_memfault <= 1'b1;
                    end
                end
                FAULT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // RAM side is a pure decode of the request register, never of live inputs.
    assign ramREN   = w_granted && !r_wen;
    assign ramWEN   = w_granted && r_wen;
    assign ramaddr  = w_granted ? r_addr : '0;
    assign ramstore = (w_granted && r_wen) ? r_store : '0;

    // Completion: the ACCESS cycle of a grant, or the single FAULT cycle.
    assign w_done = w_access || (r_state == FAULT);
    assign w_load = (r_state == FAULT) ? DATA_W'(FAULT_WORD) : ramload;

    assign iwait = !(w_done && !r_is_d);
    assign dwait = !(w_done && r_is_d);
    assign iload = (w_done && !r_is_d) ? w_load : '0;
    assign dload = (w_done && r_is_d) ? w_load : '0;

    assign memfault = r_memfault;

    // At most one RAM enable and at most one completing side.
    a_one_enable : assert property (@(posedge CLK) disable iff (!nRST) !(ramREN && ramWEN));
    a_one_done   : assert property (@(posedge CLK) disable iff (!nRST) (iwait || dwait));

endmodule
